// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, phase encoding and counter width for the
// 640x480@60 sync generator.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    ACT,
    FRONT,
    SYNCP,
    BACK
  } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus a four-segment phase FSM
// (active, front porch, sync, back porch). Used once per axis.
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             adv,
  input  logic [CNT_W-1:0] len_active,
  input  logic [CNT_W-1:0] len_front,
  input  logic [CNT_W-1:0] len_sync,
  input  logic [CNT_W-1:0] len_back,
  output logic [CNT_W-1:0] count,
  output phase_e           phase,
  output logic             wrap
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] end_act, end_front, end_sync, end_total;
  phase_e           phase_q, phase_d;

  always_comb begin
    end_act   = len_active - 1'b1;
    end_front = len_active + len_front - 1'b1;
    end_sync  = len_active + len_front + len_sync - 1'b1;
    end_total = len_active + len_front + len_sync + len_back - 1'b1;
  end

  assign wrap = adv && (count_q == end_total);

  always_comb begin
    count_d = count_q;
    if (adv) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (adv) begin
      unique case (phase_q)
        ACT:   if (count_q == end_act)   phase_d = FRONT;
        FRONT: if (count_q == end_front) phase_d = SYNCP;
        SYNCP: if (count_q == end_sync)  phase_d = BACK;
        BACK:  if (count_q == end_total) phase_d = ACT;
        default: phase_d = ACT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
      phase_q <= ACT;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count = count_q;
  // Phase being entered on this edge, so registered decodes in the parent line
  // up with the new count instead of lagging it by one tick.
  assign phase = phase_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/blanking/coordinate generator; advances one pixel per pix_en tick.
// All outputs are registered and reflect the count after the same edge.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] HA = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HF = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] HS = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] HB = CNT_W'(H_BP);
  localparam logic [CNT_W-1:0] VA = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VF = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] VS = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] VB = CNT_W'(V_BP);

  phase_e h_phase, v_phase;
  logic   h_wrap, v_wrap, v_adv;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic video_on_q, video_on_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  vga_axis_counter u_h_axis (
    .clk        (clk),
    .clr_n      (clr_n),
    .adv        (pix_en),
    .len_active (HA),
    .len_front  (HF),
    .len_sync   (HS),
    .len_back   (HB),
    .count      (pixel_x),
    .phase      (h_phase),
    .wrap       (h_wrap)
  );

  // h_wrap already includes pix_en, so the V axis steps once per line.
  assign v_adv = h_wrap & pix_en;

  vga_axis_counter u_v_axis (
    .clk        (clk),
    .clr_n      (clr_n),
    .adv        (v_adv),
    .len_active (VA),
    .len_front  (VF),
    .len_sync   (VS),
    .len_back   (VB),
    .count      (pixel_y),
    .phase      (v_phase),
    .wrap       (v_wrap)
  );

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap & v_wrap;
    if (pix_en) begin
      hsync_d    = (h_phase == SYNCP) ? SYNC_POL : ~SYNC_POL;
      vsync_d    = (v_phase == SYNCP) ? SYNC_POL : ~SYNC_POL;
      video_on_d = (h_phase == ACT) && (v_phase == ACT);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates VGA horizontal/vertical sync, blanking and pixel coordinates for a 640x480@60 Hz display. Runs on the 50 MHz board clock and advances one pixel per pixel-enable tick from the clock divider. Sits between the clock divider and the pixel/colour logic. It is the consumer end of the divider's pixel-rate output.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  board clock, 50 MHz
- clr_n  in  1  reset; asynchronous assert, active-low
- pix_en  in  1  pixel tick, one clk wide; may be held high
- hsync  out  1  horizontal sync at SYNC_POL level during sync
- vsync  out  1  vertical sync at SYNC_POL level during sync
- video_on  out  1  high only inside the active H and V window
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse when pixel_x wraps to 0
- frame_start  out  1  one-clk pulse when pixel_x and pixel_y both wrap to 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal phase FSM: H_ACT -> H_FRONT -> H_SYNCP -> H_BACK -> H_ACT.
  - Transition occurs on the pix_en edge where h_cnt reaches the phase boundary.
  - Boundaries: 639->640 FRONT, 655->656 SYNCP, 751->752 BACK, 799->0 ACT.
- Vertical phase FSM: V_ACT -> V_FRONT -> V_SYNCP -> V_BACK -> V_ACT.
  - Advances only on the H wrap edge.
  - Boundaries: 479->480 FRONT, 489->490 SYNCP, 491->492 BACK, 524->0 ACT.
- h_cnt increments on every pix_en and wraps 799->0.
- v_cnt increments only on the pix_en edge with h_cnt=799, and wraps 524->0 at that same edge.
- hsync = SYNC_POL while h phase is H_SYNCP, else ~SYNC_POL. vsync follows the same rule using the v phase.
- video_on = (h phase H_ACT) AND (v phase V_ACT).
- pixel_x/pixel_y mirror h_cnt/v_cnt. Counters are 10-bit unsigned. Out-of-range is impossible by construction.
- pix_en low: all state and outputs hold. line_start and frame_start are forced to 0.
- Reset values (immediately on clr_n low, async):
  - h_cnt=v_cnt=0, both phases ACT, pixel_x=pixel_y=0
  - hsync=vsync=~SYNC_POL (1)
  - video_on=0, line_start=frame_start=0
- First pix_en after reset release moves to x=1. video_on registers 1 on that edge.

## Timing
- All outputs are registers, updated on the same clk edge as the counters, and reflect the new count. There is no extra pipeline stage.
- line_start is high for exactly the clk cycle following the edge where h_cnt 799->0, even if pix_en stays high.
- frame_start is high for the same cycle only when v_cnt also went 524->0.
- Pixel rate with 1-in-2 pix_en: 25 MHz. Line = 800 ticks = 1600 clk. Frame = 525 lines.
- clr_n deassertion must be synchronous to clk. The bench releases it away from the clk edge.
- Reset mid-line or mid-sync: outputs go to reset values without waiting for clk.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants and derived H_TOTAL/V_TOTAL
  - phase enum {ACT, FRONT, SYNCP, BACK}
  - counter width constant (10)
- One sub-module, vga_axis_counter, instantiated twice (H and V). Its contract:
  - inputs: advance enable and the four segment lengths
  - outputs: count, phase, wrap pulse
  - V instance is enabled by the H wrap AND pix_en.

## Test plan
- Reset then 1-in-2 pix_en for one full frame -> 420000 pix_en ticks. Exactly one frame_start and 525 line_start pulses. Counters end at (0,0).
- Single line scan -> video_on high for x 0..639. hsync low for x 656..751 inclusive (96 ticks) and high elsewhere.
- Vertical sync -> vsync low only while y is 490..491 (1600 ticks total). video_on low for all y>=480.
- pix_en held low for 100 clk mid-line at x=300 -> all outputs frozen. No pulses. Resumes at x=301.
- clr_n asserted at x=700, y=490 (in sync) -> immediately hsync=vsync=1, video_on=0, x=y=0 without a clk edge.
- SYNC_POL=1 build, continuous pix_en -> hsync high for x 656..751. Line period is 800 clk.
